// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// master = loader side, slave = host link / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory image loader: length-prefixed byte frame -> 32-bit LE words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    imem_loader_if.master  bus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    // State entered once all data words (possibly none) are in.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e S_FIN = S_CHK;
`else
    localparam state_e S_FIN = S_DONE;
`endif

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        chk_q, chk_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;

    logic              accept;
    logic [15:0]       len_full;
    logic              last_word;

    assign accept    = bus.byte_valid && rdy_q;
    assign len_full  = {bus.byte_in, len_q[7:0]};
    assign last_word = (32'(idx_q) + 32'd1) == 32'(len_q);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        word_d    = word_q;
        chk_d     = chk_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    len_d   = '0;
                    idx_d   = '0;
                    lane_d  = '0;
                    word_d  = '0;
                    chk_d   = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = bus.byte_in;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'd0)
                        state_d = S_FIN;
                    else if (32'(len_full) > 32'(DEPTH))
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[{lane_q, 3'b000} +: 8] = bus.byte_in;
                    chk_d  = chk_q ^ bus.byte_in;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = idx_q;
                        wr_data_d = {bus.byte_in, word_q[23:0]};
                        idx_d     = idx_q + 1'b1;
                        word_d    = '0;
                        if (last_word)
                            state_d = S_FIN;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept)
                    state_d = (bus.byte_in == chk_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        rdy_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                 (state_d == S_DATA)   || (state_d == S_CHK);
        busy_d = rdy_d;
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        hold_d = (state_d != S_DONE);
    end

    // FSM and output registers; reset drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            lane_q    <= '0;
            word_q    <= '0;
            chk_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            chk_q     <= chk_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.byte_ready = rdy_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cpu_hold       = hold_q;

endmodule
